// File: rtl/reg_alias_pkg.sv
// rtl/reg_alias_pkg.sv - access-mode codes, FSM states and software update helper for reg_alias_bank
package reg_alias_pkg;

   typedef enum logic [2:0] {
      RW  = 3'd0,
      RO  = 3'd1,
      WO  = 3'd2,
      W1C = 3'd3,
      W1S = 3'd4,
      RC  = 3'd5,
      WC  = 3'd6
   } acc_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } fsm_state_e;

   // Widest register the helper handles; callers zero-extend and truncate.
   localparam int SW_W = 64;

   function automatic logic [SW_W-1:0] apply_sw(input acc_mode_e       mode,
                                                input logic [SW_W-1:0] cur,
                                                input logic [SW_W-1:0] wdata,
                                                input logic            is_wr,
                                                input logic            is_rd);
      logic [SW_W-1:0] nxt;
      nxt = cur;
      case (mode)
         RW, WO:  if (is_wr) nxt = wdata;
         W1C:     if (is_wr) nxt = cur & ~wdata;
         W1S:     if (is_wr) nxt = cur | wdata;
         RC:      if (is_rd) nxt = '0;
         WC:      if (is_wr) nxt = '0;
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/reg_alias_field.sv
// rtl/reg_alias_field.sv - one physical register; priority sync reset > hw pulse > software effect
module reg_alias_field
   import reg_alias_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sync_rst,
   input  logic                  hw_pulse,
   input  logic [DATA_WIDTH-1:0] hw_next,
   input  logic                  sw_en,
   input  logic [2:0]            sw_mode,
   input  logic [DATA_WIDTH-1:0] sw_wdata,
   input  logic                  sw_wr,
   input  logic                  sw_rd,
   output logic [DATA_WIDTH-1:0] value
);

   logic [SW_W-1:0] sw_next;

   assign sw_next = apply_sw(acc_mode_e'(sw_mode), SW_W'(value), SW_W'(sw_wdata), sw_wr, sw_rd);

   if (DATA_WIDTH < SW_W) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^sw_next[SW_W-1:DATA_WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         value <= INIT_VALUE;
      else if (sync_rst)
         value <= INIT_VALUE;
      else if (hw_pulse)
         value <= hw_next;
      else if (sw_en)
         value <= sw_next[DATA_WIDTH-1:0];
   end

endmodule

// File: rtl/reg_alias_bank.sv
// rtl/reg_alias_bank.sv - register slave with PHY_NUM physical registers, each seen through ALIAS_NUM aliased addresses
module reg_alias_bank
   import reg_alias_pkg::*;
#(
   parameter int                       ADDR_WIDTH = 64,
   parameter int                       DATA_WIDTH = 32,
   parameter int                       PHY_NUM    = 2,
   parameter int                       ALIAS_NUM  = 4,
   parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = '0,
   parameter logic [ALIAS_NUM-1:0][2:0] ALIAS_MODE = {RC, W1C, RO, RW},
   parameter logic [DATA_WIDTH-1:0]    INIT_VALUE = '0,
   parameter int                       ACK_DELAY  = 0
) (
   input  logic                          fsm_clk,
   input  logic                          fsm_rstn,
   input  logic                          req_vld,
   input  logic                          wr_en,
   input  logic                          rd_en,
   input  logic [ADDR_WIDTH-1:0]         addr,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   output logic                          ack_vld,
   output logic [DATA_WIDTH-1:0]         rd_data,
   input  logic [PHY_NUM*DATA_WIDTH-1:0] hw_next_value,
   input  logic [PHY_NUM-1:0]            hw_pulse,
   output logic [PHY_NUM*DATA_WIDTH-1:0] hw_curr_value,
   input  logic                          global_sync_reset_in,
   output logic                          global_sync_reset_out
);

   localparam int ALB = $clog2(ALIAS_NUM);
   localparam int ALW = (ALB > 0) ? ALB : 1;

   fsm_state_e              state, state_nxt;
   logic [3:0]              cnt, cnt_nxt;
   logic [ADDR_WIDTH:0]     diff;
   logic [ADDR_WIDTH-1:0]   idx, phy_idx;
   logic [ALW-1:0]          alias_sel;
   acc_mode_e               mode_sel;
   logic                    hit, valid, accept;
   logic [DATA_WIDTH-1:0]   rd_sel, rd_next;
   logic [DATA_WIDTH-1:0]   reg_q [PHY_NUM];

   // Extra top bit of diff is the borrow, i.e. addr below BASE_ADDR.
   assign diff      = {1'b0, addr} - {1'b0, BASE_ADDR};
   assign idx       = diff[ADDR_WIDTH-1:0] >> 2;
   assign phy_idx   = idx >> ALB;
   assign alias_sel = (ALIAS_NUM == 1) ? '0 : idx[ALW-1:0];
   assign mode_sel  = acc_mode_e'(ALIAS_MODE[alias_sel]);
   assign hit       = (addr[1:0] == 2'b00) && !diff[ADDR_WIDTH] && (phy_idx < ADDR_WIDTH'(PHY_NUM));
   assign valid     = hit && !(wr_en && rd_en);
   assign accept    = (state == IDLE) && req_vld && !global_sync_reset_in;

   for (genvar p = 0; p < PHY_NUM; p++) begin : g_phy
      reg_alias_field #(
         .DATA_WIDTH (DATA_WIDTH),
         .INIT_VALUE (INIT_VALUE)
      ) u_field (
         .clk      (fsm_clk),
         .rst_n    (fsm_rstn),
         .sync_rst (global_sync_reset_in),
         .hw_pulse (hw_pulse[p]),
         .hw_next  (hw_next_value[p*DATA_WIDTH +: DATA_WIDTH]),
         .sw_en    (accept && valid && (phy_idx == ADDR_WIDTH'(p))),
         .sw_mode  (mode_sel),
         .sw_wdata (wr_data),
         .sw_wr    (wr_en),
         .sw_rd    (rd_en),
         .value    (reg_q[p])
      );
      assign hw_curr_value[p*DATA_WIDTH +: DATA_WIDTH] = reg_q[p];
   end

   always_comb begin
      rd_sel = '0;
      for (int p = 0; p < PHY_NUM; p++)
         if (phy_idx == ADDR_WIDTH'(p)) rd_sel = reg_q[p];
   end

   assign rd_next = (valid && rd_en && (mode_sel != WO)) ? rd_sel : '0;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (req_vld) begin
               if (ACK_DELAY == 0) begin
                  state_nxt = ACK;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = 4'(ACK_DELAY - 1);
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_nxt = ACK;
            else             cnt_nxt   = cnt - 4'd1;
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (global_sync_reset_in) state_nxt = IDLE;
   end

   // ack_vld is registered off the ACK state, giving ACK_DELAY+1 cycles of latency.
   always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
      if (!fsm_rstn) begin
         state                 <= IDLE;
         cnt                   <= '0;
         ack_vld               <= 1'b0;
         rd_data               <= '0;
         global_sync_reset_out <= 1'b0;
      end else begin
         state                 <= state_nxt;
         cnt                   <= cnt_nxt;
         ack_vld               <= (state == ACK) && !global_sync_reset_in;
         global_sync_reset_out <= global_sync_reset_in;
         if (accept) rd_data <= rd_next;
      end
   end

endmodule

// File: tb/tb_reg_alias_bank.sv
// tb/tb_reg_alias_bank.sv - directed bench for reg_alias_bank with ACK_DELAY 0 and 3 instances
module tb_reg_alias_bank;
   import reg_alias_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, req_vld, wr_en, rd_en, gsr_in;
   logic [63:0] addr;
   logic [31:0] wr_data;
   logic [63:0] hw_next_value;
   logic [1:0]  hw_pulse;
   logic        ack0, ack3, gsr_out0, gsr_out3;
   logic [31:0] rd0, rd3;
   logic [63:0] hw0, hw3;
   int          errors = 0;
   int          checks = 0;
   int          lat;

   always #5 clk = ~clk;

   reg_alias_bank #(.ACK_DELAY(0), .ALIAS_MODE({RC, W1C, RO, RW})) dut0 (
      .fsm_clk(clk), .fsm_rstn(rst_n), .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en),
      .addr(addr), .wr_data(wr_data), .ack_vld(ack0), .rd_data(rd0),
      .hw_next_value(hw_next_value), .hw_pulse(hw_pulse), .hw_curr_value(hw0),
      .global_sync_reset_in(gsr_in), .global_sync_reset_out(gsr_out0));

   reg_alias_bank #(.ACK_DELAY(3), .ALIAS_MODE({RC, W1C, RO, RW})) dut3 (
      .fsm_clk(clk), .fsm_rstn(rst_n), .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en),
      .addr(addr), .wr_data(wr_data), .ack_vld(ack3), .rd_data(rd3),
      .hw_next_value(hw_next_value), .hw_pulse(hw_pulse), .hw_curr_value(hw3),
      .global_sync_reset_in(gsr_in), .global_sync_reset_out(gsr_out3));

   task automatic do_req(input logic w, input logic r, input logic [63:0] a, input logic [31:0] d,
                         input logic [1:0] hp, input logic [63:0] hn, input bit use3, output int l);
      @(negedge clk);
      req_vld = 1'b1; wr_en = w; rd_en = r; addr = a; wr_data = d;
      hw_pulse = hp; hw_next_value = hn;
      @(negedge clk);
      req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0; hw_pulse = 2'b00;
      l = 0;
      while (((use3 ? ack3 : ack0) !== 1'b1) && l < 20) begin
         @(negedge clk);
         l++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0; gsr_in = 1'b0;
      addr = '0; wr_data = '0; hw_next_value = '0; hw_pulse = '0;
      repeat (3) @(negedge clk);
      checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b exp 0", ack0); end
      checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h exp 0", rd0); end
      checks++; if (hw0 !== 64'h0) begin errors++; $display("FAIL reset_hw: got %h exp 0", hw0); end
      checks++; if (gsr_out0 !== 1'b0) begin errors++; $display("FAIL reset_gsr_out: got %b exp 0", gsr_out0); end
      checks++; if (ack3 !== 1'b0) begin errors++; $display("FAIL reset_ack3: got %b exp 0", ack3); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_rw_alias();
      do_req(1, 0, 64'h00, 32'hA5A5A5A5, 2'b00, 64'h0, 0, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL rw_write_latency: got %0d exp 1", lat); end
      do_req(0, 1, 64'h04, 32'h0, 2'b00, 64'h0, 0, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL rw_read_latency: got %0d exp 1", lat); end
      checks++; if (rd0 !== 32'hA5A5A5A5) begin errors++; $display("FAIL rw_read_data: got %h exp a5a5a5a5", rd0); end
      checks++; if (hw0 !== 64'h00000000_A5A5A5A5) begin errors++; $display("FAIL rw_hw_curr: got %h exp 00000000a5a5a5a5", hw0); end
   endtask

   task automatic test_ro_w1c();
      do_req(1, 0, 64'h14, 32'hFFFFFFFF, 2'b00, 64'h0, 0, lat);
      checks++; if (hw0[63:32] !== 32'h0) begin errors++; $display("FAIL ro_write_ignored: got %h exp 0", hw0[63:32]); end
      do_req(1, 0, 64'h10, 32'h0000FFFF, 2'b00, 64'h0, 0, lat);
      do_req(1, 0, 64'h18, 32'h000000FF, 2'b00, 64'h0, 0, lat);
      checks++; if (hw0[63:32] !== 32'h0000FF00) begin errors++; $display("FAIL w1c_result: got %h exp 0000ff00", hw0[63:32]); end
      do_req(0, 1, 64'h14, 32'h0, 2'b00, 64'h0, 0, lat);
      checks++; if (rd0 !== 32'h0000FF00) begin errors++; $display("FAIL ro_read: got %h exp 0000ff00", rd0); end
   endtask

   task automatic test_rc();
      do_req(1, 0, 64'h00, 32'h12345678, 2'b00, 64'h0, 0, lat);
      do_req(0, 1, 64'h0C, 32'h0, 2'b00, 64'h0, 0, lat);
      checks++; if (rd0 !== 32'h12345678) begin errors++; $display("FAIL rc_read_data: got %h exp 12345678", rd0); end
      checks++; if (hw0 !== 64'h0000FF00_00000000) begin errors++; $display("FAIL rc_cleared: got %h exp 0000ff0000000000", hw0); end
   endtask

   task automatic test_hw_priority();
      do_req(1, 0, 64'h00, 32'h0, 2'b01, 64'h00000000_CAFE0001, 0, lat);
      checks++; if (hw0[31:0] !== 32'hCAFE0001) begin errors++; $display("FAIL hw_beats_sw: got %h exp cafe0001", hw0[31:0]); end
      do_req(1, 0, 64'h00, 32'h00000055, 2'b10, 64'h11112222_00000000, 0, lat);
      checks++; if (hw0 !== 64'h11112222_00000055) begin errors++; $display("FAIL hw_and_sw_split: got %h exp 1111222200000055", hw0); end
   endtask

   task automatic test_miss();
      do_req(0, 1, 64'h00, 32'h0, 2'b00, 64'h0, 0, lat);
      checks++; if (rd0 !== 32'h00000055) begin errors++; $display("FAIL miss_pre_read: got %h exp 00000055", rd0); end
      do_req(0, 1, 64'h20, 32'h0, 2'b00, 64'h0, 0, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL miss_latency: got %0d exp 1", lat); end
      checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL miss_rd_data: got %h exp 0", rd0); end
      do_req(0, 1, 64'h10, 32'h0, 2'b00, 64'h0, 0, lat);
      checks++; if (rd0 !== 32'h11112222) begin errors++; $display("FAIL miss_phy1_read: got %h exp 11112222", rd0); end
      do_req(0, 1, 64'h02, 32'h0, 2'b00, 64'h0, 0, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL misalign_latency: got %0d exp 1", lat); end
      checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL misalign_rd_data: got %h exp 0", rd0); end
      do_req(1, 0, 64'h20, 32'hFFFFFFFF, 2'b00, 64'h0, 0, lat);
      do_req(0, 1, 64'h00, 32'h0, 2'b00, 64'h0, 0, lat);
      do_req(1, 1, 64'h0C, 32'hFFFFFFFF, 2'b00, 64'h0, 0, lat);
      checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL wr_rd_both_rd: got %h exp 0", rd0); end
      checks++; if (hw0 !== 64'h11112222_00000055) begin errors++; $display("FAIL miss_no_change: got %h exp 1111222200000055", hw0); end
   endtask

   task automatic test_sync_reset();
      @(negedge clk);
      gsr_in = 1'b1;
      @(negedge clk);
      gsr_in = 1'b0;
      checks++; if (hw0 !== 64'h0) begin errors++; $display("FAIL sync_reset_regs: got %h exp 0", hw0); end
      checks++; if (hw3 !== 64'h0) begin errors++; $display("FAIL sync_reset_regs3: got %h exp 0", hw3); end
      checks++; if (gsr_out0 !== 1'b1) begin errors++; $display("FAIL gsr_out_pulse: got %b exp 1", gsr_out0); end
      @(negedge clk);
      checks++; if (gsr_out0 !== 1'b0) begin errors++; $display("FAIL gsr_out_end: got %b exp 0", gsr_out0); end
   endtask

   task automatic test_ack_delay();
      int first;
      int nack;
      repeat (3) @(negedge clk);
      do_req(0, 1, 64'h20, 32'h0, 2'b00, 64'h0, 1, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL delay3_latency: got %0d exp 4", lat); end
      checks++; if (rd3 !== 32'h0) begin errors++; $display("FAIL delay3_miss_rd: got %h exp 0", rd3); end
      @(negedge clk);
      req_vld = 1'b1; wr_en = 1'b1; addr = 64'h00; wr_data = 32'h00000011;
      @(negedge clk);
      req_vld = 1'b0; wr_en = 1'b0;
      first = -1; nack = 0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (i == 1) begin req_vld = 1'b1; wr_en = 1'b1; addr = 64'h10; wr_data = 32'h0000BEEF; end
         if (i == 2) begin req_vld = 1'b0; wr_en = 1'b0; end
         if (ack3 === 1'b1) begin
            nack++;
            if (first < 0) first = i;
         end
      end
      checks++; if (first !== 4) begin errors++; $display("FAIL delay3_wait_latency: got %0d exp 4", first); end
      checks++; if (nack !== 1) begin errors++; $display("FAIL delay3_wait_ignored_acks: got %0d exp 1", nack); end
      checks++; if (hw3 !== 64'h00000000_00000011) begin errors++; $display("FAIL delay3_regs: got %h exp 0000000000000011", hw3); end
      @(negedge clk);
      req_vld = 1'b1; rd_en = 1'b1; addr = 64'h00;
      @(negedge clk);
      req_vld = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      nack = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack3 === 1'b1) nack++;
      end
      checks++; if (nack !== 0) begin errors++; $display("FAIL async_reset_drops_ack: got %0d exp 0", nack); end
   endtask

   initial begin
      test_reset();
      test_rw_alias();
      test_ro_w1c();
      test_rc();
      test_hw_priority();
      test_miss();
      test_sync_reset();
      test_ack_delay();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
